// File: rtl/fas_pkg.sv
// Shared definitions for the ripple-carry adder/subtractor: mode encoding,
// result struct and a bit-serial reference function for benches.
package fas_pkg;

  localparam logic ADD = 1'b1;
  localparam logic SUB = 1'b0;
  localparam int   MAX_WIDTH = 64;

  typedef struct packed {
    logic                 ovf;
    logic                 cout;
    logic [MAX_WIDTH-1:0] s;
  } fas_res_t;

  // Walks the same carry chain as the hardware; width must be 1..MAX_WIDTH.
  function automatic fas_res_t fas_ref(input int width,
                                       input logic [MAX_WIDTH-1:0] a,
                                       input logic [MAX_WIDTH-1:0] b,
                                       input logic cin,
                                       input logic a_ns);
    fas_res_t         r;
    logic [MAX_WIDTH:0] c;
    logic             bx;
    r    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < width; i++) begin
      bx       = b[i] ^ (a_ns == SUB);
      r.s[i]   = a[i] ^ bx ^ c[i];
      c[i+1]   = (a[i] & bx) | (a[i] & c[i]) | (bx & c[i]);
    end
    r.cout = c[width];
    r.ovf  = c[width] ^ c[width-1];
    return r;
  endfunction

endpackage

// File: rtl/fas_bit.sv
// One-bit full adder-subtractor cell; b is inverted when a_ns selects subtract.
module fas_bit
  import fas_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);

  logic w_bx;

  assign w_bx = b ^ (a_ns == SUB);
  assign s    = a ^ w_bx ^ cin;
  assign cout = (a & w_bx) | (a & cin) | (w_bx & cin);

endmodule

// File: rtl/full_add_sub.sv
// Parameterised ripple-carry adder/subtractor with a single registered output
// stage; operands are captured only when in_valid is high.
module full_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             a_ns,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic             w_ovf;

  logic             r_valid;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;

  assign w_c[0] = cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      fas_bit u_bit (
        .a    (a[gi]),
        .b    (b[gi]),
        .cin  (w_c[gi]),
        .a_ns (a_ns),
        .s    (w_s[gi]),
        .cout (w_c[gi+1])
      );
    end
  endgenerate

  // For WIDTH=1 the lower tap is the raw carry-in.
  assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

  // Result registers load only on valid so idle/X operands never reach outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_s    <= w_s;
        r_cout <= w_c[WIDTH];
        r_ovf  <= w_ovf;
      end
    end
  end

  assign out_valid = r_valid;
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_full_add_sub.sv
// Bench for full_add_sub at WIDTH=8 and WIDTH=1 side by side, checked against
// an arithmetic model every cycle plus literal directed expectations.
module tb_full_add_sub;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       cin = 1'b0;
  logic       a_ns = 1'b1;

  logic       v8, c8, o8;
  logic [7:0] s8;
  logic       v1, c1, o1;
  logic [0:0] s1;

  int checks = 0;
  int errors = 0;

  // Model state: what each DUT's outputs must currently show.
  logic       ev = 1'b0;
  logic [7:0] es8 = '0;
  logic       ec8 = 1'b0, eo8 = 1'b0;
  logic [7:0] es1 = '0;
  logic       ec1 = 1'b0, eo1 = 1'b0;

  always #5 clk = ~clk;

  full_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a_in), .b(b_in),
    .cin(cin), .a_ns(a_ns), .out_valid(v8), .s(s8), .cout(c8), .ovf(o8)
  );

  full_add_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a_in[0:0]), .b(b_in[0:0]),
    .cin(cin), .a_ns(a_ns), .out_valid(v1), .s(s1), .cout(c1), .ovf(o1)
  );

  // Plain modular arithmetic: A + (B or ~B) + cin, overflow from operand signs.
  function automatic void model(input int w, input logic [7:0] va, input logic [7:0] vb,
                                input logic vc, input logic vns,
                                output logic [7:0] rs, output logic rco, output logic rov);
    int unsigned m, ua, ub, sum;
    logic sa, sb, ss;
    m   = (32'd1 << w) - 32'd1;
    ua  = {24'd0, va} & m;
    ub  = (vns ? {24'd0, vb} : ~{24'd0, vb}) & m;
    sum = ua + ub + {31'd0, vc};
    rs  = 8'(sum & m);
    rco = sum[w];
    sa  = ua[w-1];
    sb  = ub[w-1];
    ss  = sum[w-1];
    rov = (sa == sb) && (ss != sa);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    ev = 1'b0; es8 = '0; ec8 = 1'b0; eo8 = 1'b0; es1 = '0; ec1 = 1'b0; eo1 = 1'b0;
  endtask

  // Drive one cycle of stimulus, update the model at the capturing edge.
  task automatic apply(input logic vv, input logic [7:0] va, input logic [7:0] vb,
                       input logic vc, input logic vns);
    in_valid = vv; a_in = va; b_in = vb; cin = vc; a_ns = vns;
    @(posedge clk);
    if (rst) clear_model();
    else begin
      ev = vv;
      if (vv) begin
        model(8, va, vb, vc, vns, es8, ec8, eo8);
        model(1, va, vb, vc, vns, es1, ec1, eo1);
      end
    end
    $display("txn t=%0t valid=%0b a=%02h b=%02h cin=%0b a_ns=%0b", $time, vv, va, vb, vc, vns);
    #1;
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("out_valid8", 64'(v8), 64'(ev));
    chk("s8", 64'(s8), 64'(es8));
    chk("cout8", 64'(c8), 64'(ec8));
    chk("ovf8", 64'(o8), 64'(eo8));
    chk("out_valid1", 64'(v1), 64'(ev));
    chk("s1", 64'(s1), 64'(es1[0]));
    chk("cout1", 64'(c1), 64'(ec1));
    chk("ovf1", 64'(o1), 64'(eo1));
  end

  initial begin
    logic [7:0] ms;
    logic       mc, mo;

    // Pin the model itself with hand-computed values.
    model(8, 8'h7F, 8'h01, 1'b0, 1'b1, ms, mc, mo);
    chk("model_7f_plus_1", {ms, mc, mo}, {8'h80, 1'b0, 1'b1});
    model(8, 8'h03, 8'h05, 1'b1, 1'b0, ms, mc, mo);
    chk("model_3_minus_5", {ms, mc, mo}, {8'hFE, 1'b0, 1'b0});
    model(1, 8'h00, 8'h01, 1'b1, 1'b0, ms, mc, mo);
    chk("model_w1_borrow", {ms[0], mc, mo}, {1'b1, 1'b0, 1'b1});

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state8", {v8, s8, c8, o8}, 11'd0);
    chk("reset_state1", {v1, s1, c1, o1}, 4'd0);
    rst = 1'b0;

    // WIDTH=1 directed, back to back.
    apply(1'b1, 8'h00, 8'h01, 1'b0, 1'b1);
    chk("w1_0p1", {v1, s1, c1}, 3'b110);
    apply(1'b1, 8'h01, 8'h01, 1'b0, 1'b1);
    chk("w1_1p1", {v1, s1, c1}, 3'b101);
    apply(1'b1, 8'h00, 8'h01, 1'b0, 1'b1);
    chk("w1_0p1_again", {v1, s1, c1}, 3'b110);
    apply(1'b1, 8'h01, 8'h01, 1'b1, 1'b0);
    chk("w1_1m1", {v1, s1, c1}, 3'b101);
    apply(1'b1, 8'h00, 8'h01, 1'b1, 1'b0);
    chk("w1_0m1", {v1, s1, c1}, 3'b110);

    // WIDTH=8 directed.
    apply(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1);
    chk("w8_7f_p1", {v8, s8, c8, o8}, {1'b1, 8'h80, 1'b0, 1'b1});
    apply(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1);
    chk("w8_ff_p1", {v8, s8, c8, o8}, {1'b1, 8'h00, 1'b1, 1'b0});
    apply(1'b1, 8'h05, 8'h03, 1'b1, 1'b0);
    chk("w8_5m3", {v8, s8, c8}, {1'b1, 8'h02, 1'b1});
    apply(1'b1, 8'h03, 8'h05, 1'b1, 1'b0);
    chk("w8_3m5", {v8, s8, c8, o8}, {1'b1, 8'hFE, 1'b0, 1'b0});

    // Idle holds previous result.
    apply(1'b0, 8'hAA, 8'h55, 1'b1, 1'b1);
    chk("w8_hold", {v8, s8, c8, o8}, {1'b0, 8'hFE, 1'b0, 1'b0});

    // Asynchronous reset mid-stream.
    apply(1'b1, 8'h12, 8'h34, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    chk("async_rst8", {v8, s8, c8, o8}, 11'd0);
    chk("async_rst1", {v1, s1, c1, o1}, 4'd0);
    apply(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1);
      chk("post_rst_idle8", {v8, s8, c8, o8}, 11'd0);
    end

    // Exhaustive WIDTH=1 sweep.
    for (int k = 0; k < 16; k++) begin
      logic [3:0] kk;
      kk = 4'(k);
      apply(1'b1, {7'd0, kk[0]}, {7'd0, kk[1]}, kk[2], kk[3]);
    end

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
